// File: rtl/ram_sync_nolatch_mrmw_pkg.sv
// Shared encodings and defaults for the multi-read/multi-write register-file RAM.
package ram_sync_nolatch_mrmw_pkg;

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_DATA_DEPTH = 32;

   // Init counter width; a one-bit counter is still needed for tiny depths.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ram_sync_nolatch_mrmw_init_seq.sv
// Init/run sequencer: sweeps every entry once after reset or a clear, then holds ready.
module ram_init_seq
   import ram_sync_nolatch_mrmw_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   output logic                  ready,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr
);

   localparam int unsigned CNT_W = cnt_width(DATA_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_DEPTH - 1);

   logic             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (clear) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      ready     = (state_q == ST_RUN);
      init_we   = (state_q == ST_INIT);
      init_addr = ADDR_WIDTH'(cnt_q);
   end

endmodule

// File: rtl/ram_sync_nolatch_mrmw.sv
// Parametrised NREAD x NWRITE register-file RAM with write priority, optional bypass and
// a hardware init sweep.
module ram_sync_nolatch_mrmw
   import ram_sync_nolatch_mrmw_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH,
   parameter int unsigned NREAD      = 2,
   parameter int unsigned NWRITE     = 2,
   parameter int unsigned BYPASS     = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         clear,
   output logic                         ready,
   input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
   output logic [NREAD*DATA_WIDTH-1:0]  rdata,
   input  logic [NWRITE-1:0]            we,
   input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
   input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
   output logic                         wr_conflict
);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

   logic                  init_we;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic [NWRITE-1:0]     wr_ok;
   logic [NWRITE-1:0]     wr_commit;

   ram_init_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_DEPTH (DATA_DEPTH)
   ) u_init_seq (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .ready     (ready),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   // A port may write only in RUN, outside the clear cycle, and to an existing entry.
   always_comb begin
      wr_ok = '0;
      for (int j = 0; j < int'(NWRITE); j++) begin
         wr_ok[j] = ready && !clear && we[j] &&
                    (32'(waddr[j*ADDR_WIDTH +: ADDR_WIDTH]) < DATA_DEPTH);
      end
   end

   // Highest enabled index wins a shared address; lower ports are dropped.
   always_comb begin
      wr_commit = '0;
      for (int j = int'(NWRITE) - 1; j >= 0; j--) begin
         wr_commit[j] = wr_ok[j];
         for (int k = j + 1; k < int'(NWRITE); k++) begin
            if (wr_ok[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] ==
                             waddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
               wr_commit[j] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_addr] <= INIT_VALUE;
      end
      for (int j = 0; j < int'(NWRITE); j++) begin
         if (wr_commit[j]) begin
            mem[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Bypass only forwards data that will actually commit; ascending scan lets the highest
   // port override, matching commit priority.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         if (ready && (32'(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) < DATA_DEPTH)) begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            if (BYPASS != 0) begin
               for (int j = 0; j < int'(NWRITE); j++) begin
                  if (wr_ok[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                                   raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                     rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
      end
   end

   // Full-width address compare, so out-of-range collisions are still flagged.
   always_comb begin
      wr_conflict = 1'b0;
      for (int j = 0; j < int'(NWRITE); j++) begin
         for (int k = j + 1; k < int'(NWRITE); k++) begin
            if (ready && we[j] && we[k] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                                            waddr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
               wr_conflict = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_sync_nolatch_mrmw.sv
// Bench: two instances (32-deep no bypass, 20-deep bypass) against an array-based model.
module tb_ram_sync_nolatch_mrmw;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam logic [31:0] INIT_B = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear = 1'b0;
   logic [NR*AW-1:0] raddr = '0;
   logic [NW-1:0]    we = '0;
   logic [NW*AW-1:0] waddr = '0;
   logic [NW*DW-1:0] wdata = '0;

   logic ready_a, ready_b, conf_a, conf_b;
   logic [NR*DW-1:0] rdata_a, rdata_b;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   ram_sync_nolatch_mrmw #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DATA_DEPTH (32),
      .NREAD (NR), .NWRITE (NW), .BYPASS (0), .INIT_VALUE (32'h0)
   ) dut_a (
      .clk (clk), .reset_n (reset_n), .clear (clear), .ready (ready_a),
      .raddr (raddr), .rdata (rdata_a), .we (we), .waddr (waddr), .wdata (wdata),
      .wr_conflict (conf_a)
   );

   ram_sync_nolatch_mrmw #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DATA_DEPTH (20),
      .NREAD (NR), .NWRITE (NW), .BYPASS (1), .INIT_VALUE (INIT_B)
   ) dut_b (
      .clk (clk), .reset_n (reset_n), .clear (clear), .ready (ready_b),
      .raddr (raddr), .rdata (rdata_b), .we (we), .waddr (waddr), .wdata (wdata),
      .wr_conflict (conf_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
   logic [31:0] mm [2][32];
   logic        m_ready [2];
   int          m_pos [2];

   function automatic int m_depth(input int k);
      return (k == 1) ? 20 : 32;
   endfunction

   function automatic logic [31:0] m_init(input int k);
      return (k == 1) ? INIT_B : 32'h0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) begin
            m_ready[k] <= 1'b0;
            m_pos[k]   <= 0;
         end else if (!m_ready[k]) begin
            mm[k][m_pos[k]] <= m_init(k);
            if (m_pos[k] == m_depth(k) - 1) begin
               m_ready[k] <= 1'b1;
               m_pos[k]   <= 0;
            end else begin
               m_pos[k] <= m_pos[k] + 1;
            end
         end else if (clear) begin
            m_ready[k] <= 1'b0;
            m_pos[k]   <= 0;
         end else begin
            for (int j = 0; j < NW; j++) begin
               if (we[j] && int'(waddr[j*AW +: AW]) < m_depth(k)) begin
                  mm[k][waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
               end
            end
         end
      end
   end

   function automatic logic [31:0] exp_rd(input int k, input int i);
      logic [AW-1:0] ra;
      logic [31:0]   v;
      ra = raddr[i*AW +: AW];
      if (!m_ready[k] || int'(ra) >= m_depth(k)) return 32'h0;
      v = mm[k][ra];
      if (k == 1 && !clear) begin
         for (int j = 0; j < NW; j++) begin
            if (we[j] && waddr[j*AW +: AW] == ra) v = wdata[j*DW +: DW];
         end
      end
      return v;
   endfunction

   function automatic logic exp_conf(input int k);
      return m_ready[k] && we[0] && we[1] && (waddr[0 +: AW] == waddr[AW +: AW]);
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ready_a", {31'b0, ready_a}, {31'b0, m_ready[0]});
         check("ready_b", {31'b0, ready_b}, {31'b0, m_ready[1]});
         check("conf_a", {31'b0, conf_a}, {31'b0, exp_conf(0)});
         check("conf_b", {31'b0, conf_b}, {31'b0, exp_conf(1)});
         for (int i = 0; i < NR; i++) begin
            check($sformatf("rdata_a[%0d]", i), rdata_a[i*DW +: DW], exp_rd(0, i));
            check($sformatf("rdata_b[%0d]", i), rdata_b[i*DW +: DW], exp_rd(1, i));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we    = '0;
      clear = 1'b0;
   endtask

   task automatic wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
      we[j] = 1'b1;
      waddr[j*AW +: AW] = a;
      wdata[j*DW +: DW] = d;
   endtask

   task automatic rd(input int i, input logic [AW-1:0] a);
      raddr[i*AW +: AW] = a;
   endtask

   // Counts edges until each instance reports ready; noise writes avoid addresses 0..8.
   task automatic wait_ready(input bit noisy, output int na, output int nb);
      na = -1;
      nb = -1;
      for (int c = 1; c <= 48; c++) begin
         tick();
         if (ready_a && na < 0) na = c;
         if (ready_b && nb < 0) nb = c;
         idle();
         if (noisy && !ready_a && !ready_b) begin
            for (int j = 0; j < NW; j++) begin
               if ($urandom_range(0, 1) == 1) wr(j, AW'($urandom_range(9, 31)), $urandom);
            end
         end
      end
      idle();
   endtask

   initial begin
      int na, nb;
      reset_n = 1'b0;
      tick();
      cmp_en = 1'b1;
      repeat (2) tick();
      reset_n = 1'b1;
      wait_ready(1'b0, na, nb);
      check("init_len_a", na, 32);
      check("init_len_b", nb, 20);

      for (int a = 0; a < 32; a += 2) begin
         rd(0, AW'(a));
         rd(1, AW'(a + 1));
         #3;
         check("post_init_a0", rdata_a[31:0], 32'h0);
         check("post_init_a1", rdata_a[63:32], 32'h0);
         check("post_init_b0", rdata_b[31:0], (a < 20) ? INIT_B : 32'h0);
         check("post_init_b1", rdata_b[63:32], (a + 1 < 20) ? INIT_B : 32'h0);
         tick();
      end

      // Same-address collision: port 1 wins.
      wr(0, 5, 32'hAAAA);
      wr(1, 5, 32'hBBBB);
      #3;
      check("collide_conf_a", {31'b0, conf_a}, 32'h1);
      check("collide_conf_b", {31'b0, conf_b}, 32'h1);
      tick();
      idle();
      rd(0, 5);
      #3;
      check("collide_rd_a", rdata_a[31:0], 32'hBBBB);
      check("collide_rd_b", rdata_b[31:0], 32'hBBBB);
      tick();

      // Bypass vs registered read.
      wr(0, 3, 32'h1111);
      tick();
      wr(0, 3, 32'h1234);
      rd(0, 3);
      #3;
      check("nobyp_old_a", rdata_a[31:0], 32'h1111);
      check("byp_b", rdata_b[31:0], 32'h1234);
      tick();
      idle();
      #3;
      check("nobyp_new_a", rdata_a[31:0], 32'h1234);
      tick();

      // Out-of-range writes on the 20-deep instance.
      wr(0, 4, 32'h4444);
      tick();
      idle();
      wr(0, 25, 32'hFFFF);
      wr(1, 20, 32'hEEEE);
      rd(0, 25);
      rd(1, 4);
      #3;
      check("oor_conf_b", {31'b0, conf_b}, 32'h0);
      check("oor_byp_b", rdata_b[31:0], 32'h0);
      tick();
      idle();
      #3;
      check("oor_rd25_b", rdata_b[31:0], 32'h0);
      check("oor_rd4_b", rdata_b[63:32], 32'h4444);
      check("inr_rd25_a", rdata_a[31:0], 32'hFFFF);
      tick();
      rd(0, 20);
      #3;
      check("oor_rd20_b", rdata_b[31:0], 32'h0);
      check("inr_rd20_a", rdata_a[31:0], 32'hEEEE);
      tick();

      // Clear re-runs the sweep; the write in the clear cycle is dropped.
      wr(0, 7, 32'h55);
      tick();
      idle();
      clear = 1'b1;
      wr(0, 8, 32'h99);
      rd(0, 8);
      #3;
      check("clear_cycle_ready_a", {31'b0, ready_a}, 32'h1);
      check("clear_cycle_byp_b", rdata_b[31:0], INIT_B);
      tick();
      idle();
      check("after_clear_ready_a", {31'b0, ready_a}, 32'h0);
      wait_ready(1'b1, na, nb);
      check("clear_len_a", na, 32);
      check("clear_len_b", nb, 20);
      rd(0, 7);
      rd(1, 8);
      #3;
      check("clear_rd7_a", rdata_a[31:0], 32'h0);
      check("clear_rd8_a", rdata_a[63:32], 32'h0);
      check("clear_rd7_b", rdata_b[31:0], INIT_B);
      check("clear_rd8_b", rdata_b[63:32], INIT_B);
      tick();

      // Reset in the middle of a sweep restarts it from zero.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (10) tick();
      reset_n = 1'b0;
      #1;
      check("midreset_ready_a", {31'b0, ready_a}, 32'h0);
      check("midreset_ready_b", {31'b0, ready_b}, 32'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      wait_ready(1'b0, na, nb);
      check("reset_len_a", na, 32);
      check("reset_len_b", nb, 20);

      // Randomised traffic against the model.
      for (int c = 0; c < 500; c++) begin
         we = NW'($urandom_range(0, 3));
         for (int j = 0; j < NW; j++) begin
            waddr[j*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                            : AW'($urandom_range(0, 31));
            wdata[j*DW +: DW] = $urandom;
         end
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 1) == 1) raddr[i*AW +: AW] = waddr[($urandom_range(0, 1))*AW +: AW];
            else raddr[i*AW +: AW] = AW'($urandom_range(0, 31));
         end
         clear = ($urandom_range(0, 63) == 0);
         tick();
      end
      idle();
      tick();
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
